intn_addsub_pipe: RTL and testbench

INTN_ADDSUB_PIPE -- requirements
Module: intn_addsub_pipe

---
 rtl/intn_addsub_pipe_pkg.sv | 19 +
 rtl/intn_addsub_pipe_addsub_chunk.sv | 14 +
 rtl/intn_addsub_pipe.sv | 114 +++++++++++
 tb/tb_intn_addsub_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/intn_addsub_pipe_pkg.sv
// intn_addsub_pipe_pkg: shared ALU op encodings and operand-conditioning helpers
package intn_addsub_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBC = 2'b11
  } op_e;

  function automatic logic op_inverts(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUBC);
  endfunction

  function automatic logic op_carry(input logic [1:0] op, input logic cin);
    return ((op == OP_ADDC) || (op == OP_SUBC)) ? cin : (op == OP_SUB);
  endfunction

endpackage

// File: rtl/intn_addsub_pipe_addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple segment with carry in and carry out
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/intn_addsub_pipe.sv
// intn_addsub_pipe: carry-segmented pipelined add/sub with valid/ready handshake and flags
module intn_addsub_pipe
  import intn_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int L      = STAGES - 1;

  if (CHUNK < 1) begin : bad_chunk
    $error("intn_addsub_pipe: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : bad_width
    $error("intn_addsub_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic             adv;
  logic             c0;
  logic [WIDTH-1:0] b_eff;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign b_eff    = op_inverts(op) ? ~b : b;
  assign c0       = op_carry(op, cin);

  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;
    logic [WIDTH-LO-1:0] opa, opb;
    logic [CHUNK-1:0]    so;
    logic [HI-1:0]       sn, s;
    logic                ci, vi, co, v, c;
    if (k == 0) begin : src
      assign opa = a;
      assign opb = b_eff;
      assign ci  = c0;
      assign vi  = in_valid;
      assign sn  = so;
    end else begin : src
      assign opa = g[k-1].up.ua;
      assign opb = g[k-1].up.ub;
      assign ci  = g[k-1].c;
      assign vi  = g[k-1].v;
      assign sn  = {so, g[k-1].s};
    end
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a   (opa[CHUNK-1:0]),
      .b   (opb[CHUNK-1:0]),
      .cin (ci),
      .sum (so),
      .cout(co)
    );
    // stage k: finished low sum bits, segment carry and valid advance together unless stalled
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (adv) begin
        v <= vi;
        c <= co;
        s <= sn;
      end
    end
    if (k < STAGES - 1) begin : up
      logic [WIDTH-HI-1:0] ua, ub;
      // operand segments not yet summed ride along to the next stage
      always_ff @(posedge clk) begin
        if (rst) begin
          ua <= '0;
          ub <= '0;
        end else if (adv) begin
          ua <= opa[WIDTH-LO-1:CHUNK];
          ub <= opb[WIDTH-LO-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g[L].v;
  assign sum       = g[L].s;
  assign cout      = g[L].c;

  // status flags are computed from the final segment and registered alongside the sum
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b1;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv) begin
      zero <= ~|g[L].sn;
      neg  <= g[L].so[CHUNK-1];
      ovf  <= (g[L].opa[CHUNK-1] == g[L].opb[CHUNK-1]) && (g[L].so[CHUNK-1] != g[L].opa[CHUNK-1]);
    end
  end

endmodule

// File: tb/tb_intn_addsub_pipe.sv
// tb_intn_addsub_pipe: scoreboard bench for the pipelined add/sub
module tb_intn_addsub_pipe;
  import intn_addsub_pipe_pkg::*;

  localparam int W = 16;
  localparam int C = 8;
  localparam int S = W / C;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, ovf, zero, neg;

  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cyc = 0, pop_cyc = 0, npop = 0, nstall = 0;
  logic acc = 1'b0;
  res_t pending;
  res_t q[$];

  always #5 clk = ~clk;

  intn_addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic v, input logic z, input logic n);
    return '{s: s, c: c, v: v, z: z, n: n};
  endfunction

  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] xop, input logic xc);
    logic [W-1:0] bb;
    logic         k;
    logic [W:0]   full;
    bb   = xop[0] ? ~xb : xb;
    k    = xop[1] ? xc : xop[0];
    full = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, k};
    return mk(full[W-1:0], full[W], (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]),
              full[W-1:0] == '0, full[W-1]);
  endfunction

  task automatic step();
    res_t e;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (rst) q.delete();
    else begin
      if (out_valid && !out_ready && q.size() > 0) begin
        nstall++;
        chk("hold_sum", sum, q[0].s);
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stale_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.v);
          chk("zero", zero, e.z);
          chk("neg", neg, e.n);
          npop++;
          pop_cyc = cyc;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(pending);
        acc = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] xop, input logic xc, input res_t e);
    a = xa; b = xb; op = xop; cin = xc; pending = e; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  logic [W-1:0] ta [4] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h00FF};
  logic [W-1:0] tb [4] = '{16'h0101, 16'h0001, 16'hFFFF, 16'h0001};
  logic [1:0]   to [4] = '{2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    int idx, p0, s0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    send(16'h0043, 16'h0035, OP_ADD, 1'b0, mk(16'h0078, 0, 0, 0, 0));
    repeat (4) step();
    chk("latency", pop_cyc - acc_cyc, S);

    send(16'h00FF, 16'h000F, OP_SUB,  1'b0, mk(16'h00F0, 1, 0, 0, 0));
    send(16'h0000, 16'h0001, OP_SUB,  1'b0, mk(16'hFFFF, 0, 0, 0, 1));
    send(16'hFFFF, 16'h0001, OP_ADD,  1'b0, mk(16'h0000, 1, 0, 1, 0));
    send(16'h7FFF, 16'h0001, OP_ADD,  1'b0, mk(16'h8000, 0, 1, 0, 1));
    send(16'h00FF, 16'h0000, OP_ADDC, 1'b1, mk(16'h0100, 0, 0, 0, 0));
    send(16'h0005, 16'h0003, OP_SUBC, 1'b0, mk(16'h0001, 1, 0, 0, 0));
    drain();

    idx = 0;
    p0 = npop;
    s0 = nstall;
    for (int t = 0; t < 30 && (idx < 4 || q.size() > 0); t++) begin
      in_valid = idx < 4;
      if (idx < 4) begin
        a = ta[idx]; b = tb[idx]; op = to[idx]; cin = 1'b1;
        pending = model(ta[idx], tb[idx], to[idx], 1'b1);
      end
      out_ready = !(t >= 3 && t <= 5);
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("b2b_accepts", idx, 4);
    chk("b2b_results", npop - p0, 4);
    chk("b2b_stall_cycles", nstall - s0, 3);

    send(16'h1111, 16'h2222, OP_ADD, 1'b0, model(16'h1111, 16'h2222, OP_ADD, 1'b0));
    send(16'h3333, 16'h1111, OP_SUB, 1'b0, model(16'h3333, 16'h1111, OP_SUB, 1'b0));
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'h4444; b = 16'h0001; op = OP_ADD;
    step();
    @(negedge clk);
    chk("inflight_rst_out_valid", out_valid, 0);
    chk("inflight_rst_zero", zero, 1);
    chk("inflight_rst_sum", sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    p0 = npop;
    repeat (6) step();
    chk("no_stale_after_rst", npop - p0, 0);

    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra = 16'h7FFF;
      if (i % 10 == 5) rb = 16'h8000;
      a = ra; b = rb; op = ro; cin = rc;
      pending = model(ra, rb, ro, rc);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
